// File: rtl/detector_andamento.sv
// detector_andamento: measures tap-to-tap interval and classifies it against the 60/120 BPM metronome periods.
// Optional MEDIA4_EN: report the sliding average of the last four intervals instead of the single last one.
module detector_andamento #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int METRO_60BPM = CLOCK_FREQ / 2,
  parameter int METRO_120BPM = CLOCK_FREQ / 4,
  parameter int TIMEOUT = 2 * METRO_60BPM,
  localparam int W = $clog2(TIMEOUT + 1)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         habilita,
  input  logic         tap,
  output logic [W-1:0] periodo,
  output logic         valido,
  output logic         bpm_60,
  output logic         bpm_120,
  output logic         fora_tempo,
  output logic         timeout,
  output logic [1:0]   estado_db
);
  typedef enum logic [1:0] {ESPERA = 2'd0, MEDINDO = 2'd1, EMITE = 2'd2} state_t;
  localparam logic [W-1:0] TMO = W'(TIMEOUT);
  state_t state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d, periodo_q, periodo_d;
  logic [2:0] flags_q, flags_d;
  logic tap_q, edge_w, lat, emit;
`ifdef MEDIA4_EN
  localparam int SW = W + 2;
  logic [W-1:0] hist_q [3];
  logic [W-1:0] hist_d [3];
  logic [1:0] n_q, n_d;
  logic [SW-1:0] sum;
`endif
  // returns {fora_tempo, bpm_120, bpm_60}; inclusive windows of +/- expected/8
  function automatic logic [2:0] classify(input logic [W-1:0] v);
    logic c60, c120;
    c60 = int'(v) >= METRO_60BPM - METRO_60BPM / 8 && int'(v) <= METRO_60BPM + METRO_60BPM / 8;
    c120 = !c60 && int'(v) >= METRO_120BPM - METRO_120BPM / 8 && int'(v) <= METRO_120BPM + METRO_120BPM / 8;
    return {!c60 && !c120, c120, c60};
  endfunction
  always_comb begin
    edge_w = tap & ~tap_q;
    timeout = habilita && state_q == MEDINDO && cnt_q == TMO;
    lat = habilita && state_q == MEDINDO && edge_w && !timeout;
    state_d = state_q;
    cnt_d = cnt_q;
    periodo_d = periodo_q;
    flags_d = flags_q;
`ifdef MEDIA4_EN
    hist_d = hist_q;
    n_d = n_q;
    sum = SW'(hist_q[0]) + SW'(hist_q[1]) + SW'(hist_q[2]) + SW'(cnt_q);
    emit = n_q == 2'd3;
`else
    emit = 1'b1;
`endif
    if (!habilita) begin
      state_d = ESPERA;
      cnt_d = '0;
    end else begin
      case (state_q)
        ESPERA: if (edge_w) begin
          state_d = MEDINDO;
          cnt_d = W'(1);
        end
        // a tap landing on the timeout cycle abandons the old sequence and starts a new one
        MEDINDO: if (timeout) begin
          state_d = edge_w ? MEDINDO : ESPERA;
          cnt_d = edge_w ? W'(1) : '0;
        end else if (edge_w) begin
          state_d = emit ? EMITE : MEDINDO;
          cnt_d = W'(1);
        end else cnt_d = cnt_q + W'(1);
        EMITE: begin
          state_d = MEDINDO;
          cnt_d = cnt_q + W'(1);
        end
        default: state_d = ESPERA;
      endcase
    end
`ifdef MEDIA4_EN
    if (lat) begin
      hist_d = '{cnt_q, hist_q[0], hist_q[1]};
      n_d = emit ? n_q : n_q + 2'd1;
    end
    if (lat && emit) begin
      periodo_d = W'(sum >> 2);
      flags_d = classify(periodo_d);
    end
    if (state_d == ESPERA || timeout) n_d = '0;
`else
    if (lat) begin
      periodo_d = cnt_q;
      flags_d = classify(cnt_q);
    end
`endif
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset || zera) begin
      state_q <= ESPERA;
      cnt_q <= '0;
      tap_q <= 1'b0;
      periodo_q <= '0;
      flags_q <= '0;
`ifdef MEDIA4_EN
      hist_q <= '{default: '0};
      n_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      tap_q <= tap;
      periodo_q <= periodo_d;
      flags_q <= flags_d;
`ifdef MEDIA4_EN
      hist_q <= hist_d;
      n_q <= n_d;
`endif
    end
  end
  assign periodo = periodo_q;
  assign valido = state_q == EMITE;
  assign {fora_tempo, bpm_120, bpm_60} = flags_q;
  assign estado_db = state_q;
endmodule

// File: tb/tb_detector_andamento.sv
// tb_detector_andamento: scoreboard bench at CLOCK_FREQ=64 (periods 32/16, timeout 64).
module tb_detector_andamento;
  localparam int W = 7;
  typedef struct {
    bit is_to;
    int per;
    logic [2:0] fl;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, zera = 1'b0, habilita = 1'b1, tap = 1'b0;
  logic [W-1:0] periodo;
  logic valido, bpm_60, bpm_120, fora_tempo, timeout;
  logic [1:0] estado_db;
  int checks = 0, errors = 0;
  exp_t q[$];
  exp_t e;
  detector_andamento #(.CLOCK_FREQ(64)) dut (
    .clock(clk), .reset(rst), .zera(zera), .habilita(habilita), .tap(tap),
    .periodo(periodo), .valido(valido), .bpm_60(bpm_60), .bpm_120(bpm_120),
    .fora_tempo(fora_tempo), .timeout(timeout), .estado_db(estado_db)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic do_tap();
    tap = 1'b1;
    @(negedge clk);
    tap = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic push_v(input int per, input logic [2:0] fl);
    q.push_back('{1'b0, per, fl});
  endtask
  task automatic push_to();
    q.push_back('{1'b1, 0, 3'b000});
  endtask
  // flags expectations are {fora_tempo, bpm_120, bpm_60}
  always @(negedge clk) begin
    #1;
    if (valido || timeout) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: valido=%b timeout=%b periodo=%0d", valido, timeout, periodo);
      end else begin
        e = q.pop_front();
        if (timeout != e.is_to || valido == e.is_to ||
            (!e.is_to && (int'(periodo) != e.per || {fora_tempo, bpm_120, bpm_60} != e.fl))) begin
          errors++;
          $display("FAIL scoreboard: got valido=%b timeout=%b periodo=%0d flags=%b expected timeout=%b periodo=%0d flags=%b",
                   valido, timeout, periodo, {fora_tempo, bpm_120, bpm_60}, e.is_to, e.per, e.fl);
        end
      end
    end
  end
  initial begin
    idle(2);
    chk("reset_periodo", int'(periodo), 0);
    chk("reset_flags", int'({fora_tempo, bpm_120, bpm_60}), 0);
    chk("reset_state", int'(estado_db), 0);
    rst = 1'b0;
    idle(2);
    // three taps 32 apart
    do_tap(); idle(31);
    push_v(32, 3'b001); do_tap(); idle(31);
    push_v(32, 3'b001); do_tap(); idle(3);
    chk("t1_bpm60_held", int'(bpm_60), 1);
    habilita = 1'b0; idle(2);
    chk("t1_disable_state", int'(estado_db), 0);
    chk("t1_disable_periodo", int'(periodo), 32);
    // 16, 36 (window edge), 37 (outside)
    habilita = 1'b1; idle(1);
    do_tap(); idle(15);
    push_v(16, 3'b010); do_tap(); idle(35);
    push_v(36, 3'b001); do_tap(); idle(36);
    push_v(37, 3'b100); push_to(); do_tap();
    // abandoned sequence after the last tap
    idle(62);
    chk("t3_no_timeout_early", int'(timeout), 0);
    chk("t3_still_measuring", int'(estado_db), 1);
    idle(1);
    chk("t3_timeout_pulse", int'(timeout), 1);
    idle(1);
    chk("t3_state_espera", int'(estado_db), 0);
    chk("t3_periodo_held", int'(periodo), 37);
    // tap exactly on the timeout cycle restarts as a first tap
    do_tap(); idle(63);
    push_to(); do_tap(); idle(15);
    push_v(16, 3'b010); do_tap(); idle(10);
    chk("t4_pre_reset_state", int'(estado_db), 1);
    #2 rst = 1'b1;
    #1;
    chk("t4_async_periodo", int'(periodo), 0);
    chk("t4_async_flags", int'({fora_tempo, bpm_120, bpm_60}), 0);
    chk("t4_async_state", int'(estado_db), 0);
    @(negedge clk); rst = 1'b0; idle(1);
    do_tap(); idle(15);
    push_v(16, 3'b010); do_tap(); idle(3);
    zera = 1'b1; tap = 1'b1;
    @(negedge clk); zera = 1'b0; tap = 1'b0;
    chk("t4_zera_state", int'(estado_db), 0);
    chk("t4_zera_periodo", int'(periodo), 0);
    idle(2);
    chk("t4_zera_stays_espera", int'(estado_db), 0);
    // disable mid-measure while taps continue
    do_tap(); idle(9);
    habilita = 1'b0; idle(2);
    chk("t5_disabled_state", int'(estado_db), 0);
    do_tap(); idle(15); do_tap(); idle(15);
    chk("t5_disabled_state2", int'(estado_db), 0);
    chk("t5_flags_held", int'({fora_tempo, bpm_120, bpm_60}), 0);
    habilita = 1'b1; idle(3);
    do_tap(); idle(15);
    push_v(16, 3'b010); do_tap(); idle(3);
    chk("t5_bpm120", int'(bpm_120), 1);
    habilita = 1'b0;
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
